// File: rtl/tff_pkg.sv
// tff_pkg: shared helpers and parameter legality check for the modulo toggle counter
package tff_pkg;
  function automatic int clog2_mod(input int m);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) w = ((1 << i) < m) ? i + 1 : w;
    return w;
  endfunction
  function automatic bit mod_ok(input int width, input int modulus);
    return (modulus >= 2) && (clog2_mod(modulus) <= width);
  endfunction
endpackage

// File: rtl/tff_mod_counter_if.sv
// tff_mod_counter_if: control and status bundle of the modulo toggle counter
interface tff_mod_counter_if #(parameter int WIDTH = 4);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] t_vec;
  logic             tc;
  logic             wrap;
  modport master (output en, up_dn, load, load_val, input count, t_vec, tc, wrap);
  modport slave (input en, up_dn, load, load_val, output count, t_vec, tc, wrap);
endinterface

// File: rtl/tff_cell.sv
// tff_cell: one toggle bit with async active-low clear and a synchronous load
module tff_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic t,
  input  logic ld,
  input  logic d,
  output logic q
);
  logic q_q, q_d;
  // load takes the bit directly, otherwise toggle on t
  always_comb q_d = ld ? d : q_q ^ t;
  // bit storage, cleared immediately by reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= 1'b0;
    else q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/tff_mod_counter.sv
// tff_mod_counter: modulo-N up/down counter built from a bank of toggle cells
module tff_mod_counter
  import tff_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input logic               clk,
  input logic               rst_n,
  tff_mod_counter_if.slave  bus
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  if (!mod_ok(WIDTH, MODULUS)) begin : g_bad_params
    $error("tff_mod_counter: MODULUS must be in 2..2**WIDTH");
  end
  logic [WIDTH-1:0] count, next_count, load_clamp, t_vec;
  logic             tc, wrap_q, wrap_d;
  // next value: load clamps, counting wraps at the terminal value and folds illegal counts back in range
  always_comb begin
    load_clamp = (bus.load_val > MAX) ? MAX : bus.load_val;
    tc = bus.en & (bus.up_dn ? (count == MAX) : (count == '0));
    next_count = bus.load ? load_clamp :
                 !bus.en ? count :
                 bus.up_dn ? ((count >= MAX) ? '0 : count + 1'b1) :
                 ((count == '0) || (count > MAX)) ? MAX : count - 1'b1;
    t_vec = count ^ next_count;
    wrap_d = tc & ~bus.load;
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .t     (t_vec[i]),
      .ld    (bus.load),
      .d     (load_clamp[i]),
      .q     (count[i])
    );
  end
  // wrap pulse shown alongside the freshly wrapped count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wrap_q <= 1'b0;
    else wrap_q <= wrap_d;
  assign bus.count = count;
  assign bus.t_vec = t_vec;
  assign bus.tc    = tc;
  assign bus.wrap  = wrap_q;
endmodule

// File: tb/tb_tff_mod_counter.sv
// tb_tff_mod_counter: directed checks of the modulo-10 toggle counter
module tb_tff_mod_counter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  tff_mod_counter_if #(.WIDTH(4)) bus ();
  tff_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic drive(input logic ld, input logic [3:0] lv, input logic e, input logic u);
    bus.load = ld;
    bus.load_val = lv;
    bus.en = e;
    bus.up_dn = u;
    #1;
  endtask
  initial begin
    drive(0, 0, 0, 1);
    #2;
    chk("rst_count", bus.count, 0);
    chk("rst_wrap", bus.wrap, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 1, 1);
    step(); step(); step();
    chk("up3_count", bus.count, 3);
    chk("up3_tvec", bus.t_vec, 4'b0111);
    chk("up3_tc", bus.tc, 0);
    drive(1, 9, 0, 1);
    step();
    chk("ld9_count", bus.count, 9);
    chk("ld9_wrap", bus.wrap, 0);
    drive(0, 0, 1, 1);
    chk("upwrap_tc", bus.tc, 1);
    chk("upwrap_tvec", bus.t_vec, 4'b1001);
    step();
    chk("upwrap_count", bus.count, 0);
    chk("upwrap_wrap", bus.wrap, 1);
    drive(0, 0, 0, 1);
    step();
    chk("upwrap_pulse_end", bus.wrap, 0);
    chk("hold0_count", bus.count, 0);
    drive(0, 0, 1, 0);
    chk("dnwrap_tc", bus.tc, 1);
    chk("dnwrap_tvec", bus.t_vec, 4'b1001);
    step();
    chk("dnwrap_count", bus.count, 9);
    chk("dnwrap_wrap", bus.wrap, 1);
    step();
    chk("dn8_count", bus.count, 8);
    chk("dn8_wrap", bus.wrap, 0);
    drive(1, 13, 1, 1);
    chk("clamp_tvec", bus.t_vec, 4'b0001);
    step();
    chk("clamp_count", bus.count, 9);
    chk("clamp_wrap", bus.wrap, 0);
    drive(1, 0, 0, 1);
    step();
    chk("ld0_count", bus.count, 0);
    drive(1, 13, 1, 0);
    chk("ldwin_tc", bus.tc, 1);
    chk("ldwin_tvec", bus.t_vec, 4'b1001);
    step();
    chk("ldwin_count", bus.count, 9);
    chk("ldwin_wrap", bus.wrap, 0);
    drive(1, 5, 1, 1);
    chk("ld5_tvec", bus.t_vec, 4'b1100);
    step();
    chk("ld5_count", bus.count, 5);
    drive(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      chk("hold_tvec", bus.t_vec, 0);
      chk("hold_tc", bus.tc, 0);
      step();
      chk("hold_count", bus.count, 5);
    end
    drive(1, 4, 0, 1);
    step();
    chk("ld4_count", bus.count, 4);
    drive(0, 0, 1, 1);
    step();
    chk("flip1", bus.count, 5);
    drive(0, 0, 1, 0);
    step();
    chk("flip2", bus.count, 4);
    drive(0, 0, 1, 1);
    step();
    chk("flip3", bus.count, 5);
    drive(0, 0, 1, 0);
    step();
    chk("flip4", bus.count, 4);
    drive(1, 7, 0, 1);
    step();
    chk("ld7_count", bus.count, 7);
    drive(1, 2, 1, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_count", bus.count, 0);
    chk("midrst_wrap", bus.wrap, 0);
    step();
    chk("midrst_hold", bus.count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 1, 1);
    step();
    chk("post_rst_count", bus.count, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
